// File: rtl/zero_io_channels.sv
// zero_io_channels: per-channel I/O buffers for the zero-language VM.
//
// Each channel has an input FIFO (IN_DEPTH words) and an output ring
// (OUT_DEPTH words).
// - The host preloads input FIFOs through ld_*.
// - The VM reads them with in_size/in_req and writes output rings with out_req.
// - The host drains output rings through dr_*.
// - A push into a full ring overwrites its oldest word and sets the sticky
//   overflow bit for that channel.
//
// Ports:
//   clock, reset               single clock, async active-high reset
//   ld_valid/chan/data/ready   host load into an input FIFO
//   in_chan, in_size           VM channel select and FIFO occupancy (comb)
//   in_req -> in_valid/in_empty/in_data   VM pop, result one cycle later
//   out_req/chan/data          VM push into an output ring
//   dr_req/chan -> dr_valid/dr_data       host drain, one cycle later
//   out_count                  occupancy of ring dr_chan (comb)
//   overflow, underflow        sticky error flags
//
// Optional feature, macro ZERO_IO_EXPECT_CHECK_EN:
//   - Adds ports exp_valid/exp_chan/exp_data, success and checked.
//   - Each channel gets an expected-word FIFO, checked against every out_req.
module zero_io_channels #(
    parameter int WIDTH     = 12,
    parameter int CHANNELS  = 2,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 16,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IW = $clog2(IN_DEPTH + 1),
    localparam int OW = $clog2(OUT_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic [CW-1:0]       ld_chan,
    input  logic [WIDTH-1:0]    ld_data,
    output logic                ld_ready,
    input  logic [CW-1:0]       in_chan,
    output logic [IW-1:0]       in_size,
    input  logic                in_req,
    output logic                in_valid,
    output logic                in_empty,
    output logic [WIDTH-1:0]    in_data,
    input  logic                out_req,
    input  logic [CW-1:0]       out_chan,
    input  logic [WIDTH-1:0]    out_data,
    input  logic                dr_req,
    input  logic [CW-1:0]       dr_chan,
    output logic                dr_valid,
    output logic [WIDTH-1:0]    dr_data,
    output logic [OW-1:0]       out_count,
    output logic [CHANNELS-1:0] overflow,
    output logic                underflow
`ifdef ZERO_IO_EXPECT_CHECK_EN
    ,
    input  logic                exp_valid,
    input  logic [CW-1:0]       exp_chan,
    input  logic [WIDTH-1:0]    exp_data,
    output logic                success,
    output logic [15:0]         checked
`endif
);
    localparam int IPW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    // Buffer RAMs carry no reset; only pointers and counts are cleared.
    logic [WIDTH-1:0] in_mem  [CHANNELS][IN_DEPTH];
    logic [WIDTH-1:0] out_mem [CHANNELS][OUT_DEPTH];

    logic [CHANNELS-1:0][IPW-1:0] in_rd_q, in_rd_d, in_wr_q, in_wr_d;
    logic [CHANNELS-1:0][IW-1:0]  in_cnt_q, in_cnt_d;
    logic [CHANNELS-1:0][OPW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
    logic [CHANNELS-1:0][OW-1:0]  out_cnt_q, out_cnt_d;

    logic             in_valid_q, in_valid_d, in_empty_q, in_empty_d;
    logic [WIDTH-1:0] in_data_q, in_data_d, dr_data_q, dr_data_d;
    logic             dr_valid_q, dr_valid_d, underflow_q, underflow_d;
    logic [CHANNELS-1:0] overflow_q, overflow_d;

    // Per-channel strobes. Channel indices with no matching channel never hit,
    // so out-of-range requests fall out naturally.
    logic [CHANNELS-1:0] ld_we, pop_hit, pop_ok, dr_ok, push_hit, ovw;

    assign in_valid  = in_valid_q;
    assign in_empty  = in_empty_q;
    assign in_data   = in_data_q;
    assign dr_valid  = dr_valid_q;
    assign dr_data   = dr_data_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        ld_ready  = 1'b0;
        in_size   = '0;
        out_count = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ld_chan == CW'(c)) ld_ready = (in_cnt_q[c] != IW'(IN_DEPTH));
            if (in_chan == CW'(c)) in_size = in_cnt_q[c];
            if (dr_chan == CW'(c)) out_count = out_cnt_q[c];
        end
    end

    always_comb begin
        in_rd_d     = in_rd_q;
        in_wr_d     = in_wr_q;
        in_cnt_d    = in_cnt_q;
        out_rd_d    = out_rd_q;
        out_wr_d    = out_wr_q;
        out_cnt_d   = out_cnt_q;
        in_valid_d  = 1'b0;
        in_empty_d  = 1'b0;
        in_data_d   = in_data_q;
        dr_valid_d  = 1'b0;
        dr_data_d   = dr_data_q;
        ld_we       = '0;
        pop_hit     = '0;
        pop_ok      = '0;
        dr_ok       = '0;
        push_hit    = '0;
        ovw         = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ld_we[c]    = ld_valid && (ld_chan == CW'(c)) && (in_cnt_q[c] != IW'(IN_DEPTH));
            pop_hit[c]  = in_req && (in_chan == CW'(c));
            pop_ok[c]   = pop_hit[c] && (in_cnt_q[c] != '0);
            dr_ok[c]    = dr_req && (dr_chan == CW'(c)) && (out_cnt_q[c] != '0);
            push_hit[c] = out_req && (out_chan == CW'(c));
            // A same-cycle drain frees the slot, so only overwrite if no drain.
            ovw[c]      = push_hit[c] && !dr_ok[c] && (out_cnt_q[c] == OW'(OUT_DEPTH));

            if (pop_hit[c]) begin
                in_valid_d = 1'b1;
                in_empty_d = !pop_ok[c];
            end
            if (pop_ok[c]) begin
                in_data_d  = in_mem[c][in_rd_q[c]];
                in_rd_d[c] = in_rd_q[c] + IPW'(1);
            end
            if (ld_we[c]) in_wr_d[c] = in_wr_q[c] + IPW'(1);
            if (ld_we[c] && !pop_ok[c])      in_cnt_d[c] = in_cnt_q[c] + IW'(1);
            else if (!ld_we[c] && pop_ok[c]) in_cnt_d[c] = in_cnt_q[c] - IW'(1);

            if (dr_ok[c]) begin
                dr_valid_d = 1'b1;
                dr_data_d  = out_mem[c][out_rd_q[c]];
            end
            if (dr_ok[c] || ovw[c]) out_rd_d[c] = out_rd_q[c] + OPW'(1);
            if (push_hit[c]) out_wr_d[c] = out_wr_q[c] + OPW'(1);
            if (push_hit[c] && !ovw[c] && !dr_ok[c])  out_cnt_d[c] = out_cnt_q[c] + OW'(1);
            else if (!push_hit[c] && dr_ok[c])        out_cnt_d[c] = out_cnt_q[c] - OW'(1);
        end
        underflow_d = underflow_q | (|(pop_hit & ~pop_ok));
        overflow_d  = overflow_q | ovw;
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (ld_we[c])    in_mem[c][in_wr_q[c]]   <= ld_data;
            if (push_hit[c]) out_mem[c][out_wr_q[c]] <= out_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_rd_q     <= '0;
            in_wr_q     <= '0;
            in_cnt_q    <= '0;
            out_rd_q    <= '0;
            out_wr_q    <= '0;
            out_cnt_q   <= '0;
            in_valid_q  <= 1'b0;
            in_empty_q  <= 1'b0;
            in_data_q   <= '0;
            dr_valid_q  <= 1'b0;
            dr_data_q   <= '0;
            overflow_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            in_rd_q     <= in_rd_d;
            in_wr_q     <= in_wr_d;
            in_cnt_q    <= in_cnt_d;
            out_rd_q    <= out_rd_d;
            out_wr_q    <= out_wr_d;
            out_cnt_q   <= out_cnt_d;
            in_valid_q  <= in_valid_d;
            in_empty_q  <= in_empty_d;
            in_data_q   <= in_data_d;
            dr_valid_q  <= dr_valid_d;
            dr_data_q   <= dr_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef ZERO_IO_EXPECT_CHECK_EN
    logic [WIDTH-1:0] exp_mem [CHANNELS][OUT_DEPTH];
    logic [CHANNELS-1:0][OPW-1:0] exp_rd_q, exp_rd_d, exp_wr_q, exp_wr_d;
    logic [CHANNELS-1:0][OW-1:0]  exp_cnt_q, exp_cnt_d;
    logic [CHANNELS-1:0]          exp_we, exp_pop;
    logic                         success_q, success_d;
    logic [15:0]                  checked_q, checked_d;

    assign success = success_q;
    assign checked = checked_q;

    always_comb begin
        exp_rd_d  = exp_rd_q;
        exp_wr_d  = exp_wr_q;
        exp_cnt_d = exp_cnt_q;
        success_d = success_q;
        checked_d = checked_q;
        exp_we    = '0;
        exp_pop   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            exp_we[c]  = exp_valid && (exp_chan == CW'(c)) && (exp_cnt_q[c] != OW'(OUT_DEPTH));
            exp_pop[c] = push_hit[c] && (exp_cnt_q[c] != '0);
            // A push with nothing expected counts as a failure but not as a check.
            if (push_hit[c] && (!exp_pop[c] || (exp_mem[c][exp_rd_q[c]] != out_data)))
                success_d = 1'b0;
            if (exp_pop[c] && (checked_q != 16'hFFFF)) checked_d = checked_q + 16'd1;
            if (exp_pop[c]) exp_rd_d[c] = exp_rd_q[c] + OPW'(1);
            if (exp_we[c])  exp_wr_d[c] = exp_wr_q[c] + OPW'(1);
            if (exp_we[c] && !exp_pop[c])      exp_cnt_d[c] = exp_cnt_q[c] + OW'(1);
            else if (!exp_we[c] && exp_pop[c]) exp_cnt_d[c] = exp_cnt_q[c] - OW'(1);
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++)
            if (exp_we[c]) exp_mem[c][exp_wr_q[c]] <= exp_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_rd_q  <= '0;
            exp_wr_q  <= '0;
            exp_cnt_q <= '0;
            success_q <= 1'b1;
            checked_q <= '0;
        end else begin
            exp_rd_q  <= exp_rd_d;
            exp_wr_q  <= exp_wr_d;
            exp_cnt_q <= exp_cnt_d;
            success_q <= success_d;
            checked_q <= checked_d;
        end
    end
`endif

endmodule

// File: tb/tb_zero_io_channels.sv
// Bench for zero_io_channels (default parameters).
// A queue-based reference model predicts registered results; they are pushed
// to scoreboards when requests are driven and popped when the DUT responds.
module tb_zero_io_channels;
    localparam int IN_DEPTH  = 8;
    localparam int OUT_DEPTH = 16;

    typedef logic [11:0] word_t;
    typedef struct { logic empty; word_t data; } in_exp_t;
    typedef struct {
        logic ld_v; word_t ld_d; logic in_r; logic out_r; word_t out_d; logic dr_r;
        int x_size; int x_cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    logic ld_valid, ld_ready, in_req, in_valid, in_empty, out_req, dr_req, dr_valid, underflow;
    logic [0:0] ld_chan, in_chan, out_chan, dr_chan;
    word_t ld_data, in_data, out_data, dr_data;
    logic [3:0] in_size;
    logic [4:0] out_count;
    logic [1:0] overflow;
`ifdef ZERO_IO_EXPECT_CHECK_EN
    logic exp_valid, success;
    logic [0:0] exp_chan;
    word_t exp_data;
    logic [15:0] checked;
`endif

    zero_io_channels dut (
        .clock(clock), .reset(reset),
        .ld_valid(ld_valid), .ld_chan(ld_chan), .ld_data(ld_data), .ld_ready(ld_ready),
        .in_chan(in_chan), .in_size(in_size), .in_req(in_req), .in_valid(in_valid),
        .in_empty(in_empty), .in_data(in_data),
        .out_req(out_req), .out_chan(out_chan), .out_data(out_data),
        .dr_req(dr_req), .dr_chan(dr_chan), .dr_valid(dr_valid), .dr_data(dr_data),
        .out_count(out_count), .overflow(overflow), .underflow(underflow)
`ifdef ZERO_IO_EXPECT_CHECK_EN
        , .exp_valid(exp_valid), .exp_chan(exp_chan), .exp_data(exp_data),
        .success(success), .checked(checked)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    word_t   in_m [2][$];
    word_t   out_m [2][$];
    logic [1:0] ovf_m;
    logic    udf_m;
    word_t   last_in;
    in_exp_t in_sb [$];
    word_t   dr_sb [$];
    vec_t    tbl [18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        ld_valid = 0; ld_chan = 0; ld_data = 0; in_req = 0; in_chan = 0;
        out_req = 0; out_chan = 0; out_data = 0; dr_req = 0; dr_chan = 0;
`ifdef ZERO_IO_EXPECT_CHECK_EN
        exp_valid = 0; exp_chan = 0; exp_data = 0;
`endif
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            in_m[c].delete();
            out_m[c].delete();
        end
        in_sb.delete();
        dr_sb.delete();
        ovf_m = '0; udf_m = 0; last_in = '0;
    endtask

    task automatic check_regs();
        in_exp_t e;
        word_t d;
        chk("in_valid", in_valid, in_sb.size());
        if (in_sb.size() != 0) begin
            e = in_sb.pop_front();
            if (in_valid) begin
                chk("in_empty", in_empty, e.empty);
                chk("in_data", in_data, e.data);
            end
        end
        chk("dr_valid", dr_valid, dr_sb.size());
        if (dr_sb.size() != 0) begin
            d = dr_sb.pop_front();
            if (dr_valid) chk("dr_data", dr_data, d);
        end
        chk("overflow", overflow, ovf_m);
        chk("underflow", underflow, udf_m);
    endtask

    // Inputs are already driven; check comb outputs, advance model, clock once.
    task automatic tick();
        logic ld_ok;
        #1;
        chk("in_size", in_size, in_m[in_chan].size());
        chk("out_count", out_count, out_m[dr_chan].size());
        chk("ld_ready", ld_ready, in_m[ld_chan].size() < IN_DEPTH);
        ld_ok = ld_valid && (in_m[ld_chan].size() < IN_DEPTH);
        if (in_req) begin
            if (in_m[in_chan].size() > 0) begin
                last_in = in_m[in_chan].pop_front();
                in_sb.push_back('{1'b0, last_in});
            end else begin
                in_sb.push_back('{1'b1, last_in});
                udf_m = 1'b1;
            end
        end
        if (ld_ok) in_m[ld_chan].push_back(ld_data);
        if (dr_req && out_m[dr_chan].size() > 0) dr_sb.push_back(out_m[dr_chan].pop_front());
        if (out_req) begin
            if (out_m[out_chan].size() == OUT_DEPTH) begin
                void'(out_m[out_chan].pop_front());
                ovf_m[out_chan] = 1'b1;
            end
            out_m[out_chan].push_back(out_data);
        end
        @(posedge clock);
        #1;
        idle();
        check_regs();
    endtask

    initial begin
        idle();
        model_clear();
        reset = 1;
        #12;
        chk("rst_in_valid", in_valid, 0);
        chk("rst_in_data", in_data, 0);
        chk("rst_dr_valid", dr_valid, 0);
        chk("rst_dr_data", dr_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_in_size", in_size, 0);
        chk("rst_out_count", out_count, 0);
`ifdef ZERO_IO_EXPECT_CHECK_EN
        chk("rst_success", success, 1);
        chk("rst_checked", checked, 0);
`endif
        @(posedge clock);
        #1;
        reset = 0;

        // VM loop on ch0: load 33,22,11 then {inSize; in; out size; out word}
        tbl[0]  = '{1, 12'd33, 0, 0, 12'd0,  0, 0, 0};
        tbl[1]  = '{1, 12'd22, 0, 0, 12'd0,  0, 1, 0};
        tbl[2]  = '{1, 12'd11, 0, 0, 12'd0,  0, 2, 0};
        tbl[3]  = '{0, 12'd0,  0, 1, 12'd3,  0, 3, 0};
        tbl[4]  = '{0, 12'd0,  1, 0, 12'd0,  0, 3, 1};
        tbl[5]  = '{0, 12'd0,  0, 1, 12'd33, 0, 2, 1};
        tbl[6]  = '{0, 12'd0,  0, 1, 12'd2,  0, 2, 2};
        tbl[7]  = '{0, 12'd0,  1, 0, 12'd0,  0, 2, 3};
        tbl[8]  = '{0, 12'd0,  0, 1, 12'd22, 0, 1, 3};
        tbl[9]  = '{0, 12'd0,  0, 1, 12'd1,  0, 1, 4};
        tbl[10] = '{0, 12'd0,  1, 0, 12'd0,  0, 1, 5};
        tbl[11] = '{0, 12'd0,  0, 1, 12'd11, 0, 0, 5};
        for (int i = 0; i < 6; i++) tbl[12+i] = '{0, 12'd0, 0, 0, 12'd0, 1, 0, 6 - i};
        for (int i = 0; i < 18; i++) begin
            ld_valid = tbl[i].ld_v; ld_data = tbl[i].ld_d; in_req = tbl[i].in_r;
            out_req = tbl[i].out_r; out_data = tbl[i].out_d; dr_req = tbl[i].dr_r;
            #1;
            chk("tbl_in_size", in_size, tbl[i].x_size);
            chk("tbl_out_count", out_count, tbl[i].x_cnt);
            tick();
        end
        chk("tbl_last_drain", dr_data, 11);

        // Pop on empty ch1: empty flag, data held, underflow set
        in_req = 1; in_chan = 1;
        tick();
        chk("empty_pop_flag", in_empty, 1);
        chk("empty_pop_data", in_data, 11);
        chk("empty_pop_udf", underflow, 1);
        ld_valid = 1; ld_chan = 1; ld_data = 12'd77;
        tick();
        in_req = 1; in_chan = 1;
        tick();
        chk("pop_after_load", in_data, 77);

        // Overwrite wrap on ch0
        for (int v = 1; v <= 18; v++) begin
            out_req = 1; out_chan = 0; out_data = word_t'(v);
            tick();
        end
        #1;
        chk("wrap_count", out_count, 16);
        chk("wrap_overflow", overflow, 2'b01);
        for (int i = 0; i < 16; i++) begin
            dr_req = 1; dr_chan = 0;
            tick();
            if (i == 0) chk("wrap_first", dr_data, 3);
        end
        chk("wrap_last", dr_data, 18);
        dr_req = 1; dr_chan = 0;
        tick();

        // Full ring ch1 with simultaneous push and drain
        for (int i = 0; i < 16; i++) begin
            out_req = 1; out_chan = 1; out_data = word_t'(200 + i);
            tick();
        end
        out_req = 1; out_chan = 1; out_data = 12'd99; dr_req = 1; dr_chan = 1;
        tick();
        chk("full_rw_data", dr_data, 200);
        chk("full_rw_ovf", overflow, 2'b01);
        dr_chan = 1;
        #1;
        chk("full_rw_count", out_count, 16);
        for (int i = 0; i < 16; i++) begin
            dr_req = 1; dr_chan = 1;
            tick();
        end
        chk("full_rw_last", dr_data, 99);

        // Same-cycle load and pop on ch0
        ld_valid = 1; ld_chan = 0; ld_data = 12'd7;
        tick();
        ld_valid = 1; ld_chan = 0; ld_data = 12'd5; in_req = 1; in_chan = 0;
        tick();
        chk("ldpop_data", in_data, 7);
        chk("ldpop_size", in_size, 1);
        in_req = 1; in_chan = 0;
        tick();
        chk("ldpop_next", in_data, 5);

        // Fill ch1 input FIFO past full, mixed with independent ch0 traffic
        for (int i = 0; i < 9; i++) begin
            ld_valid = 1; ld_chan = 1; ld_data = word_t'(300 + i);
            out_req = 1; out_chan = 0; out_data = word_t'(i);
            dr_req = (i > 3); dr_chan = 0; in_chan = 1;
            tick();
        end
        in_chan = 1;
        #1;
        chk("fifo_full_size", in_size, 8);

        // Reset mid-operation suppresses the pending pop
        in_req = 1; in_chan = 1; dr_req = 1; dr_chan = 0;
        reset = 1;
        #1;
        chk("midrst_in_size", in_size, 0);
        chk("midrst_out_count", out_count, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_udf", underflow, 0);
        @(posedge clock);
        #1;
        chk("midrst_in_valid", in_valid, 0);
        chk("midrst_dr_valid", dr_valid, 0);
        chk("midrst_in_data", in_data, 0);
        idle();
        model_clear();
        reset = 0;
        ld_valid = 1; ld_chan = 1; ld_data = 12'd42;
        tick();
        in_req = 1; in_chan = 1;
        tick();
        chk("post_rst_pop", in_data, 42);

`ifdef ZERO_IO_EXPECT_CHECK_EN
        for (int v = 1; v <= 3; v++) begin
            exp_valid = 1; exp_chan = 0; exp_data = word_t'(v);
            tick();
        end
        out_req = 1; out_chan = 0; out_data = 12'd1;
        tick();
        out_req = 1; out_chan = 0; out_data = 12'd2;
        tick();
        chk("exp_success_ok", success, 1);
        out_req = 1; out_chan = 0; out_data = 12'd4;
        tick();
        chk("exp_success_bad", success, 0);
        chk("exp_checked", checked, 3);
        reset = 1;
        #1;
        chk("exp_rst_success", success, 1);
        chk("exp_rst_checked", checked, 0);
        chk("exp_rst_count", out_count, 0);
        chk("exp_rst_size", in_size, 0);
        @(posedge clock);
        #1;
        model_clear();
        reset = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/zero_io_channels.md
Name: zero_io_channels

Overview:
- Multi-channel I/O block for the zero-language VM running on the FPGA.
- Replaces the fixed input array, input position counter and wrapping output array with parametrised per-channel buffers.
- Serves the VM's in, inSize and out instructions.
- Lets the host preload input channels and drain output channels at run time.
- Sits between the VM instruction engine and the host/test harness.

Parameters:
- WIDTH, 12, memory element width in bits
- CHANNELS, 2, number of independent in/out channel pairs (>=1)
- IN_DEPTH, 8, entries per input FIFO (power of 2)
- OUT_DEPTH, 16, entries per output ring (power of 2)
- CW = max(1,$clog2(CHANNELS)); IW = $clog2(IN_DEPTH+1); OW = $clog2(OUT_DEPTH+1) (localparams)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- ld_valid  in  1  host loads one input word
- ld_chan  in  CW  target input channel
- ld_data  in  WIDTH  word to load
- ld_ready  out  1  combinational: input FIFO ld_chan not full
- in_chan  in  CW  channel addressed by the VM for inSize/in
- in_size  out  IW  combinational: registered occupancy of input FIFO in_chan
- in_req  in  1  VM in instruction: pop one word
- in_valid  out  1  registered: pop result available, one cycle after in_req
- in_empty  out  1  registered: the pop attempted on an empty FIFO
- in_data  out  WIDTH  registered popped word
- out_req  in  1  VM out instruction: push one word
- out_chan  in  CW  output channel
- out_data  in  WIDTH  word to push
- dr_req  in  1  host drains oldest word from an output ring
- dr_chan  in  CW  ring to drain
- dr_valid  out  1  registered: dr_data valid, one cycle after dr_req
- dr_data  out  WIDTH  registered drained word
- out_count  out  OW  combinational: occupancy of ring dr_chan
- overflow  out  CHANNELS  sticky: per-channel output ring overwrote its oldest entry
- underflow  out  1  sticky: any in_req hit an empty FIFO

Behaviour:
- Reset:
  - All read/write pointers and counts = 0.
  - in_valid, in_empty, dr_valid, overflow and underflow = 0.
  - in_data and dr_data = 0.
  - Buffer RAM contents are not cleared.
- Load:
  - ld_valid && ld_ready writes ld_data at the FIFO tail and count+1.
  - ld_valid while full is dropped; no state change.
- in_req, FIFO non-empty:
  - Next cycle: in_valid=1, in_empty=0, in_data = head word.
  - Head pointer advances; count-1.
- in_req, FIFO empty:
  - Next cycle: in_valid=1, in_empty=1, in_data holds its previous value.
  - underflow is set.
  - The VM leaves its destination unchanged.
- in_valid and dr_valid are single-cycle pulses. Back-to-back requests are allowed every cycle.
- Same-cycle load and in_req on one channel:
  - The pop sees the pre-cycle state; a word loaded this cycle is not poppable this cycle.
  - Net count = count + load - pop.
- out_req, ring not full: write at the tail; count+1.
- out_req, ring full:
  - Overwrite the oldest entry; head and tail both advance; count stays OUT_DEPTH.
  - overflow[out_chan] is set.
  - This is the modulo wrap of the VM out channel.
- dr_req, ring non-empty: next cycle dr_valid=1, dr_data = oldest word; head advances.
- dr_req, ring empty: dr_valid stays 0; no state change.
- Same-cycle out_req and dr_req on one channel:
  - The drain is evaluated on the pre-cycle state, then the push.
  - If the ring was full, the drain frees the slot: no overwrite, no overflow.
  - If the ring was empty, only the push occurs.
- Operations on different channels are fully independent in the same cycle.
- Pointers wrap modulo depth.
- Channel indices >= CHANNELS: the request is ignored; in_size and out_count read 0.
- Reset asserted mid-operation:
  - Immediately clears all pointers, counts and flags.
  - Pending valid pulses are suppressed.

Optional Feature:
- Macro: ZERO_IO_EXPECT_CHECK_EN.
- When defined:
  - Adds ports exp_valid (in,1), exp_chan (in,CW), exp_data (in,WIDTH), success (out,1), checked (out,16).
  - Host preloads a per-channel expected FIFO of OUT_DEPTH entries.
  - Every accepted out_req pops that channel's expected FIFO and compares against out_data.
  - Any mismatch, or a push with the expected FIFO empty, clears sticky success.
  - success resets to 1; checked counts compared words and saturates at 16'hFFFF.
- When undefined: none of these ports or their storage exist. Behaviour is otherwise identical.

Test Plan:
- Load ch0 with 33,22,11; loop {in_size; in; out size; out word} on ch0 -> in_size reads 3,2,1,0; drain ch0 yields 3,33,2,22,1,11; underflow=0.
- in_req on empty ch1 -> in_valid=1, in_empty=1, in_data unchanged, underflow=1; the next load then pop returns the loaded value.
- Push 1..18 into ch0 (OUT_DEPTH=16) -> out_count=16, overflow[0]=1, overflow[1]=0; drain yields 3..18.
- Ring ch1 full with 16 words, out_req 99 and dr_req in the same cycle -> dr_data = oldest, overflow[1] stays 0, last drained word = 99.
- Load ch0 with 5 while popping ch0 (count 1, head 7) in the same cycle -> in_data=7, in_size stays 1; next pop returns 5.
- With ZERO_IO_EXPECT_CHECK_EN: expect 1,2,3 on ch0, push 1,2,4 -> success=0 after the third push, checked=3; assert reset mid-run -> success=1, checked=0, all counts 0.
